serial_2_parallel: RTL and testbench
====================================

# serial_2_parallel

Receive-side SPI deserializer for the RP2350 → FPGA link: oversamples the RP2350's SPI mode-0 signals (SCK, MOSI, active-low CS) on the FPGA system clock and assembles 16-bit MSB-first words. It presents each word to the Kalman filter input stage over a valid/ready handshake. Malformed frames and words the filter cannot accept are reported, never silently forwarded.

## Interface
- DATA_W, 16, word width in bits (filter sample width)
- SYNC_STAGES, 2, synchronizer depth for rp2350_* inputs (≥2)
- clk  in  1  FPGA system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- rp2350_sck  in  1  serial clock from RP2350, asynchronous to clk, idle low
- rp2350_mosi  in  1  serial data, MSB first, valid on sck rising edge
- rp2350_cs  in  1  chip select, active low, asynchronous
- filter_input_data  out  DATA_W  received word
- filter_input_valid  out  1  word held on filter_input_data
- filter_input_ready  in  1  filter accepts word when valid && ready
- frame_err  out  1  one-cycle pulse: CS rose mid-word
- overrun  out  1  one-cycle pulse: word completed while holding register full and not being drained
- parity_err  out  1  one-cycle pulse: parity mismatch (0 unless S2P_PARITY_EN)

## Operation
- Inputs pass through SYNC_STAGES-flop synchronizers (reset to sck=0, cs=1, mosi=0); one further register provides previous-sck for rising-edge detect.
- FSM states:
  - WAIT_IDLE: entered on reset; go IDLE when synced cs==1. Ignores any frame in progress at reset.
  - IDLE: go SHIFT when synced cs==0; bit_cnt cleared.
  - SHIFT: on each detected sck rise, shift_reg <= {shift_reg[DATA_W-2:0], mosi_sync}, bit_cnt++. When bit_cnt reaches DATA_W (FRAME_BITS with parity), word completes, bit_cnt←0, stay in SHIFT (back-to-back words within one CS allowed). Synced cs==1 → IDLE; if bit_cnt≠0, discard partial word, pulse frame_err.
- Word completion with holding register empty, or valid && ready in the same cycle: load filter_input_data, valid=1, no overrun.
- Word completion while valid && !ready: new word dropped, held word kept, overrun pulses.
- valid clears on valid && ready unless a new word loads that cycle.
- sck rise and cs rise in the same synced cycle: cs wins; the edge is ignored.
- Electrical requirement: sck high and low phases each ≥ SYNC_STAGES+1 clk periods.

## Timing
- Reset: filter_input_data=0, filter_input_valid=0, frame_err=0, overrun=0, parity_err=0, state WAIT_IDLE, bit_cnt=0.
- Latency: valid asserts SYNC_STAGES+2 clk cycles after the final sck rise at the pin.
- Error pulses are exactly one clk wide, registered, and coincident with the completion/cs-detect cycle +1.
- filter_input_data stable while valid && !ready.

## Configuration
- S2P_PARITY_EN defined: each word is DATA_W+1 sck bits; the last bit is even parity over the data bits. On mismatch the word is dropped, parity_err pulses, and valid/data are untouched. CS rising after DATA_W bits but before the parity bit is a frame_err.
- Undefined: DATA_W-bit frames; parity_err tied 0.

## Structure
- kalman_pkg holds: DATA_W default constant, s2p_state_t enum {WAIT_IDLE, IDLE, SHIFT}, and FRAME_BITS (DATA_W or DATA_W+1, selected by the macro).
- Sub-module sync_2ff: parameterized-depth synchronizer with reset value parameter, instantiated once per rp2350_* input.

## Test plan
- Reset, cs low, send 0xA5C3 (sck=clk/8), ready=1 → single valid pulse with data 0xA5C3, SYNC_STAGES+2 cycles after the last sck rise; no error pulses.
- One CS frame with 0x0001, 0xFFFF, 0x8000, ready=1 → three valid words in order, no frame_err.
- 9 bits then cs high, then full 0x1234 → frame_err pulse once; only 0x1234 delivered.
- ready=0, send 0x1111 then 0x2222 → data holds 0x1111, overrun pulses once; raise ready → 0x1111 accepted, valid drops.
- Assert rst with cs low mid-word, release, finish the frame, cs high, send 0x00FF → no output from the interrupted frame; 0x00FF delivered.
- With S2P_PARITY_EN, send 0x0003 with parity bit 1 → parity_err pulse, no valid; with parity bit 0 → 0x0003 delivered.

Source files
------------

// File: rtl/kalman_pkg.sv
// ---------------------------------------------------------------------------
// kalman_pkg
// Shared definitions for the RP2350 -> FPGA SPI receive path.
//   DEFAULT_DATA_W : default filter sample width (bits)
//   PARITY_BITS    : 1 when S2P_PARITY_EN is defined, else 0
//   FRAME_BITS     : sck bits per word (DEFAULT_DATA_W + PARITY_BITS)
//   s2p_state_t    : deserializer FSM states
//   parity_xor     : XOR-reduction helper used for even-parity checking
// Configuration macro: S2P_PARITY_EN (adds an even-parity bit per word).
// ---------------------------------------------------------------------------
package kalman_pkg;

  localparam int DEFAULT_DATA_W = 16;

`ifdef S2P_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_BITS = DEFAULT_DATA_W + PARITY_BITS;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } s2p_state_t;

  // XOR of all bits; zero means the vector has even weight.
  function automatic logic parity_xor(input logic [31:0] i_vec);
    return ^i_vec;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Multi-flop synchronizer for a single asynchronous input.
//   STAGES  : number of flops in the chain (>= 2)
//   RST_VAL : value every flop takes during reset
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   i_d  in  asynchronous input
//   o_q  out synchronized output
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/serial_2_parallel.sv
// ---------------------------------------------------------------------------
// serial_2_parallel
// Receive-side SPI (mode 0) deserializer for the RP2350 -> FPGA link.
// Oversamples SCK/MOSI/CS on clk, assembles MSB-first words and hands them
// to the Kalman filter input stage over valid/ready.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   rp2350_sck/mosi/cs   asynchronous SPI pins (cs active low)
//   filter_input_data    received word (stable while valid && !ready)
//   filter_input_valid   word is held on filter_input_data
//   filter_input_ready   filter accepts word when valid && ready
//   frame_err            1-cycle pulse: CS rose mid-word
//   overrun              1-cycle pulse: word completed while holding reg full
//   parity_err           1-cycle pulse: parity mismatch (S2P_PARITY_EN only)
// Configuration macro: S2P_PARITY_EN (one trailing even-parity bit per word).
// ---------------------------------------------------------------------------
module serial_2_parallel
  import kalman_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rp2350_sck,
  input  logic              rp2350_mosi,
  input  logic              rp2350_cs,
  output logic [DATA_W-1:0] filter_input_data,
  output logic              filter_input_valid,
  input  logic              filter_input_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int FRAME_W = DATA_W + PARITY_BITS;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int SET_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_W);
  localparam logic [SET_W-1:0] SETTLE_CNT = SET_W'(SYNC_STAGES);

  logic w_sck_s, w_mosi_s, w_cs_s, w_sck_rise;
  logic r_sck_prev;
  s2p_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [SET_W-1:0]   r_settle;
  logic w_settled, w_word_done, w_shift_en, w_frame_err, w_parity_ok;
  logic w_load, w_drop_full;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] r_data;
  logic r_valid, r_frame_err, r_overrun, r_parity_err;

  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .i_d(rp2350_sck), .o_q(w_sck_s));
  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(rp2350_mosi), .o_q(w_mosi_s));
  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(rp2350_cs), .o_q(w_cs_s));

  // Previous synced sck for rising-edge detection; settle counter so that
  // WAIT_IDLE only trusts cs once the synchronizer holds real pin values
  // (its reset value of cs=1 would otherwise fake an idle bus).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_prev <= 1'b0;
      r_settle   <= '0;
    end else begin
      r_sck_prev <= w_sck_s;
      if (!w_settled) begin
        r_settle <= r_settle + SET_W'(1);
      end else begin
        r_settle <= r_settle;
      end
    end
  end

  assign w_sck_rise  = w_sck_s & ~r_sck_prev;
  assign w_settled   = (r_settle == SETTLE_CNT);
  // bit_cnt sits at FRAME_W for one cycle after the last bit shifts in.
  assign w_word_done = (r_state == SHIFT) && (r_bit_cnt == FRAME_CNT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_IDLE: if (w_settled && w_cs_s) w_state_nxt = IDLE; else w_state_nxt = WAIT_IDLE;
      IDLE:      if (!w_cs_s) w_state_nxt = SHIFT; else w_state_nxt = IDLE;
      SHIFT:     if (w_cs_s) w_state_nxt = IDLE; else w_state_nxt = SHIFT;
      default:   w_state_nxt = WAIT_IDLE;
    endcase
  end

  // FSM outputs: cs rising wins over a simultaneous sck rise.
  always_comb begin
    w_shift_en  = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      SHIFT: begin
        if (w_cs_s) begin
          // A word that has just completed is still delivered, not an error.
          w_frame_err = (r_bit_cnt != '0) && (r_bit_cnt != FRAME_CNT);
        end else begin
          w_shift_en = w_sck_rise;
        end
      end
      default: begin
        w_shift_en  = 1'b0;
        w_frame_err = 1'b0;
      end
    endcase
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_mosi_s};
      end else begin
        r_shift <= r_shift;
      end
      if ((r_state != SHIFT) || w_cs_s) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= w_word_done ? CNT_W'(1) : r_bit_cnt + CNT_W'(1);
      end else if (w_word_done) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
    end
  end

`ifdef S2P_PARITY_EN
  // Data plus even-parity bit must have even weight.
  assign w_parity_ok = (parity_xor(32'(r_shift)) == 1'b0);
  assign w_word      = r_shift[FRAME_W-1:1];
`else
  assign w_parity_ok = 1'b1;
  assign w_word      = r_shift;
`endif

  assign w_load      = w_word_done && w_parity_ok && (!r_valid || filter_input_ready);
  assign w_drop_full = w_word_done && w_parity_ok && r_valid && !filter_input_ready;

  // Holding register, handshake and registered error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && filter_input_ready) begin
        r_data  <= r_data;
        r_valid <= 1'b0;
      end else begin
        r_data  <= r_data;
        r_valid <= r_valid;
      end
      r_frame_err  <= w_frame_err;
      r_overrun    <= w_drop_full;
      r_parity_err <= w_word_done && !w_parity_ok;
    end
  end

  assign filter_input_data  = r_data;
  assign filter_input_valid = r_valid;
  assign frame_err          = r_frame_err;
  assign overrun            = r_overrun;
  assign parity_err         = r_parity_err;

endmodule

// File: tb/tb_serial_2_parallel.sv
module tb_serial_2_parallel;

  localparam int DW = 16;
  localparam int SS = 2;
`ifdef S2P_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic clk = 1'b0;
  logic rst, sck, mosi, cs, ready;
  logic [DW-1:0] data;
  logic valid, ferr, ovr, perr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic prev_valid = 1'b0;
  logic [DW-1:0] exp_q[$];

  serial_2_parallel #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .rp2350_sck(sck), .rp2350_mosi(mosi), .rp2350_cs(cs),
    .filter_input_data(data), .filter_input_valid(valid),
    .filter_input_ready(ready),
    .frame_err(ferr), .overrun(ovr), .parity_err(perr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected words on each handshake, checks latency, counts pulses.
  always @(negedge clk) begin
    if (valid && !prev_valid) chk("latency", 32'(cyc - last_rise), 32'(SS + 2));
    if (valid && ready) begin
      if (exp_q.size() == 0) chk("spurious_word", 32'(exp_q.size()), 32'd1);
      else chk("data", 32'(data), 32'(exp_q.pop_front()));
    end
    prev_valid = valid;
    if (ferr) n_ferr++;
    if (ovr) n_ovr++;
    if (perr) n_perr++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // One sck period = 8 clk: 4 low (mosi set up), 4 high.
  task automatic send_bit(input logic b);
    mosi = b;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    last_rise = cyc;
    repeat (4) @(posedge clk);
    #1 sck = 1'b0;
  endtask

  task automatic send_raw(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    send_raw(w);
`ifdef S2P_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cs_high();
    repeat (4) @(posedge clk);
    #1 cs = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b1; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ferr", 32'(ferr), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    repeat (6) @(posedge clk);
    #1;

    // 1: single word
    cs_low();
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3);
    cs_high();
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_ferr", 32'(n_ferr), 32'd0);
    chk("t1_ovr", 32'(n_ovr), 32'd0);
    chk("t1_perr", 32'(n_perr), 32'd0);

    // 2: back-to-back words in one frame
    cs_low();
    exp_q.push_back(16'h0001); exp_q.push_back(16'hFFFF); exp_q.push_back(16'h8000);
    send_word(16'h0001); send_word(16'hFFFF); send_word(16'h8000);
    cs_high();
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    chk("t2_ferr", 32'(n_ferr), 32'd0);

    // 3: truncated frame, then a good one
    cs_low();
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    cs_high();
    chk("t3_ferr_pulse", 32'(n_ferr), 32'd1);
    cs_low();
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    cs_high();
    chk("t3_ferr_total", 32'(n_ferr), 32'd1);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: overrun while filter stalls
    ready = 1'b0;
    cs_low();
    exp_q.push_back(16'h1111);
    send_word(16'h1111);
    send_word(16'h2222);
    cs_high();
    @(negedge clk);
    chk("t4_hold_data", 32'(data), 32'h1111);
    chk("t4_hold_valid", 32'(valid), 32'h1);
    chk("t4_ovr", 32'(n_ovr), 32'd1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_valid_drop", 32'(valid), 32'h0);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // 5: reset mid-word is ignored until cs returns high
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 5; i < FB; i++) send_bit(1'b0);
    cs_high();
    cs_low();
    exp_q.push_back(16'h00FF);
    send_word(16'h00FF);
    cs_high();
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    chk("t5_ferr", 32'(n_ferr), 32'd1);
    chk("t5_ovr", 32'(n_ovr), 32'd1);

`ifdef S2P_PARITY_EN
    // 6: parity mismatch dropped, correct parity delivered
    cs_low();
    send_raw(16'h0003); send_bit(1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_perr", 32'(n_perr), 32'd1);
    exp_q.push_back(16'h0003);
    send_raw(16'h0003); send_bit(1'b0);
    cs_high();
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_perr_total", 32'(n_perr), 32'd1);
`else
    chk("perr_tied", 32'(n_perr), 32'd0);
`endif

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
